// File: rtl/bmem_pkg.sv
// bmem_pkg: shared constants and types for the burst-memory arbiter.
//   BEATS   beats per cache line
//   BEAT_W  width of one memory beat
//   LINE_W  width of one cache line
//   ADDR_W  address width (line aligned, low 5 bits zero)
package bmem_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic {IDLE, WRITE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bmem_line_assembler.sv
// bmem_line_assembler: collects the beats of one read return for a single
// requester and presents the finished line with a one-cycle resp pulse.
//   clk, rst      clock, asynchronous active-low reset
//   issue         read command for this requester issued this cycle
//   issue_addr    address of that command (latched)
//   rvalid/raddr/rbeat  memory read-return beat stream
//   pend          a read for this requester is outstanding
//   match         current return beat belongs to this requester
//   resp          one-cycle pulse, line valid
//   line          assembled line, held until the next resp
module bmem_line_assembler #(
  parameter int BEATS  = bmem_pkg::BEATS,
  parameter int ADDR_W = bmem_pkg::ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue,
  input  logic [ADDR_W-1:0]                issue_addr,
  input  logic                             rvalid,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic [bmem_pkg::BEAT_W-1:0]      rbeat,
  output logic                             pend,
  output logic                             match,
  output logic                             resp,
  output logic [BEATS*bmem_pkg::BEAT_W-1:0] line
);
  import bmem_pkg::*;

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW = BEATS * BEAT_W;

  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     cnt_q;
  logic [LW-1:0]     acc_q;
  logic [LW-1:0]     next_line;
  logic              last;

  // The resp cycle still counts as pending so a request that is still held
  // during resp is not seen as a fresh one.
  assign match = rvalid && pend && !resp && (raddr == addr_q);
  assign last  = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    next_line = acc_q;
    next_line[BEAT_W*cnt_q +: BEAT_W] = rbeat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= 1'b0;
      resp   <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      line   <= '0;
    end else begin
      resp <= 1'b0;
      if (issue) begin
        pend   <= 1'b1;
        addr_q <= issue_addr;
        cnt_q  <= '0;
      end else if (resp) begin
        pend <= 1'b0;
      end
      if (match) begin
        acc_q <= next_line;
        if (last) begin
          cnt_q <= '0;
          resp  <= 1'b1;
          line  <= next_line;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the single burst-memory port between the icache
// (reads) and the dcache (reads and 4-beat writebacks). Requests are issued
// round-robin; read returns are routed to their owner by address.
//   clk, rst                          clock, asynchronous active-low reset
//   i_addr/i_read -> i_rdata/i_resp   icache line read
//   d_addr/d_read/d_write/d_wdata -> d_rdata/d_resp   dcache read / writeback
//   bmem_addr/read/write/wdata, bmem_rdy               memory command side
//   bmem_rvalid/raddr/rdata                            memory read return
// Optional build macro: BMEM_ARB_PERF_EN adds saturating performance
// counters (perf_i_reqs, perf_d_reqs, perf_wr_bursts, perf_conflict_cycles),
// reachable through hierarchy only.
//
// state | meaning
// IDLE  | arbitrate; a read grant pulses bmem_read for one cycle
// WRITE | stream the dcache line, one beat per cycle with bmem_rdy high
module bmem_arbiter #(
  parameter int BEATS  = bmem_pkg::BEATS,
  parameter int ADDR_W = bmem_pkg::ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_W-1:0]                 i_addr,
  input  logic                              i_read,
  output logic [BEATS*bmem_pkg::BEAT_W-1:0] i_rdata,
  output logic                              i_resp,
  input  logic [ADDR_W-1:0]                 d_addr,
  input  logic                              d_read,
  input  logic                              d_write,
  input  logic [BEATS*bmem_pkg::BEAT_W-1:0] d_wdata,
  output logic [BEATS*bmem_pkg::BEAT_W-1:0] d_rdata,
  output logic                              d_resp,
  output logic [ADDR_W-1:0]                 bmem_addr,
  output logic                              bmem_read,
  output logic                              bmem_write,
  output logic [bmem_pkg::BEAT_W-1:0]       bmem_wdata,
  input  logic                              bmem_rdy,
  input  logic                              bmem_rvalid,
  input  logic [ADDR_W-1:0]                 bmem_raddr,
  input  logic [bmem_pkg::BEAT_W-1:0]       bmem_rdata
);
  import bmem_pkg::*;

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  arb_state_t    state;
  owner_t        rr;
  logic [CW-1:0] beat;
  logic          wr_resp;
  logic          d_wpend;
  logic          i_pend, d_rpend, d_pend;
  logic          i_elig, d_elig;
  logic          grant_i, grant_d;
  logic          i_match, d_match;
  logic          i_asm_resp, d_asm_resp;

  assign d_pend = d_rpend | d_wpend;
  assign i_elig = i_read && !i_pend;
  assign d_elig = (d_read || d_write) && !d_pend;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && bmem_rdy) begin
      if (i_elig && d_elig) begin
        grant_i = (rr == OWN_I);
        grant_d = (rr == OWN_D);
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr        <= OWN_I;
      beat      <= '0;
      bmem_read <= 1'b0;
      bmem_addr <= '0;
      d_wpend   <= 1'b0;
      wr_resp   <= 1'b0;
    end else begin
      bmem_read <= 1'b0;
      wr_resp   <= 1'b0;
      if (wr_resp) d_wpend <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            bmem_read <= 1'b1;
            bmem_addr <= i_addr;
            rr        <= OWN_D;
          end else if (grant_d) begin
            bmem_addr <= d_addr;
            rr        <= OWN_I;
            if (d_write) begin
              state   <= WRITE;
              beat    <= '0;
              d_wpend <= 1'b1;
            end else begin
              bmem_read <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bmem_rdy) begin
            if (beat == CW'(BEATS - 1)) begin
              state   <= IDLE;
              beat    <= '0;
              wr_resp <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write beats are gated by bmem_rdy so that a cycle with bmem_write high
  // is exactly one accepted beat; a stall simply holds the beat index.
  assign bmem_write = (state == WRITE) && bmem_rdy;
  assign bmem_wdata = (state == WRITE) ? d_wdata[BEAT_W*beat +: BEAT_W] : '0;

  bmem_line_assembler #(.BEATS(BEATS), .ADDR_W(ADDR_W)) u_asm_i (
    .clk        (clk),
    .rst        (rst),
    .issue      (grant_i),
    .issue_addr (i_addr),
    .rvalid     (bmem_rvalid),
    .raddr      (bmem_raddr),
    .rbeat      (bmem_rdata),
    .pend       (i_pend),
    .match      (i_match),
    .resp       (i_asm_resp),
    .line       (i_rdata)
  );

  bmem_line_assembler #(.BEATS(BEATS), .ADDR_W(ADDR_W)) u_asm_d (
    .clk        (clk),
    .rst        (rst),
    .issue      (grant_d && !d_write),
    .issue_addr (d_addr),
    .rvalid     (bmem_rvalid),
    .raddr      (bmem_raddr),
    .rbeat      (bmem_rdata),
    .pend       (d_rpend),
    .match      (d_match),
    .resp       (d_asm_resp),
    .line       (d_rdata)
  );

  assign i_resp = i_asm_resp;
  assign d_resp = d_asm_resp | wr_resp;

  // A return that no outstanding read claims is dropped by the hardware.
  a_return_claimed: assert property (@(posedge clk) disable iff (!rst)
    bmem_rvalid |-> (i_match || d_match));
  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(bmem_read && bmem_write));

`ifdef BMEM_ARB_PERF_EN
  logic [31:0] perf_i_reqs;
  logic [31:0] perf_d_reqs;
  logic [31:0] perf_wr_bursts;
  logic [31:0] perf_conflict_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_reqs          <= '0;
      perf_d_reqs          <= '0;
      perf_wr_bursts       <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (grant_i) perf_i_reqs <= sat_inc(perf_i_reqs);
      if (grant_d) perf_d_reqs <= sat_inc(perf_d_reqs);
      if (grant_d && d_write) perf_wr_bursts <= sat_inc(perf_wr_bursts);
      if (i_elig && d_elig) perf_conflict_cycles <= sat_inc(perf_conflict_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: scoreboard bench for bmem_arbiter. Requester tasks push
// expected lines/beats into queues; a negedge monitor pops and compares
// whenever the DUT presents resp or write beats. Memory content is a fixed
// function of address, so the expected line is derived from address alone.
module tb_bmem_arbiter;
  import bmem_pkg::*;

  localparam int TMO = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic         bmem_read, bmem_write, bmem_rdy, bmem_rvalid;
  logic [255:0] i_rdata, d_wdata, d_rdata;
  logic [63:0]  bmem_wdata, bmem_rdata;

  typedef struct {logic [31:0] addr; int cyc;} cmd_t;
  typedef struct {logic is_wr; logic [255:0] line;} dexp_t;
  typedef struct {logic [31:0] addr; logic [63:0] data;} wexp_t;

  cmd_t         cmd_q[$];
  logic [255:0] exp_i[$];
  dexp_t        exp_d[$];
  wexp_t        exp_w[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int n_reads = 0, n_wbeats = 0;
  logic [255:0] last_i, last_d;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdy(bmem_rdy), .bmem_rvalid(bmem_rvalid),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [31:0] a, input int k);
    return {a ^ 32'h5A17_0000, 32'hBEA7_0000 + 32'(k)};
  endfunction

  // Beat k lands in bits [64k +: 64]: line = {D,C,B,A}.
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[64*k +: 64] = mem_word(a, k);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string got, input string exp);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %s expected %s", name, got, exp);
  endtask

  // Monitor / scoreboard
  initial begin
    wexp_t w;
    dexp_t e;
    logic [255:0] li;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_i = '0;
        last_d = '0;
      end else begin
        check("rd_wr_exclusive", 256'(bmem_read && bmem_write), 256'(0));
        if (bmem_read) begin
          cmd_q.push_back('{bmem_addr, cyc});
          n_reads++;
        end
        if (bmem_write) begin
          n_wbeats++;
          if (exp_w.size() == 0) fail_msg("wr_beat", "unexpected beat", "no beat");
          else begin
            w = exp_w.pop_front();
            check("wr_addr", 256'(bmem_addr), 256'(w.addr));
            check("wr_data", 256'(bmem_wdata), 256'(w.data));
          end
        end
        if (i_resp) begin
          if (exp_i.size() == 0) fail_msg("i_resp", "unexpected i_resp", "no i_resp");
          else begin
            li = exp_i.pop_front();
            check("i_rdata", i_rdata, li);
            last_i = li;
          end
        end else check("i_rdata_hold", i_rdata, last_i);
        if (d_resp) begin
          if (exp_d.size() == 0) fail_msg("d_resp", "unexpected d_resp", "no d_resp");
          else begin
            e = exp_d.pop_front();
            if (e.is_wr) check("d_rdata_hold_wr", d_rdata, last_d);
            else begin
              check("d_rdata", d_rdata, e.line);
              last_d = e.line;
            end
          end
        end else check("d_rdata_hold", d_rdata, last_d);
      end
    end
  end

  task automatic wait_cmds(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      if (cmd_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) fail_msg("cmd_wait", "timeout", "bmem_read issued");
  endtask

  task automatic mem_return(input logic [31:0] a, output int last_cyc);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = mem_word(a, k);
    end
    last_cyc = cyc;
    @(posedge clk); #1;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  task automatic serve_reads(input int n, input bit reverse, input int gap);
    bit ok;
    cmd_t c;
    int lc;
    wait_cmds(n, ok);
    if (ok) begin
      repeat (gap) @(posedge clk);
      for (int j = 0; j < n; j++) begin
        c = reverse ? cmd_q.pop_back() : cmd_q.pop_front();
        mem_return(c.addr, lc);
      end
    end
  endtask

  task automatic i_req(input logic [31:0] a, output int rc);
    rc = -1;
    exp_i.push_back(mem_line(a));
    @(posedge clk); #1;
    i_addr = a;
    i_read = 1'b1;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      if (i_resp) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      fail_msg("i_resp_wait", "timeout", "i_resp");
      exp_i.delete();
    end
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic d_req(input bit wr, input logic [31:0] a, input logic [255:0] wd, output int rc);
    rc = -1;
    exp_d.push_back('{wr, wr ? 256'(0) : mem_line(a)});
    if (wr) for (int k = 0; k < 4; k++) exp_w.push_back('{a, wd[64*k +: 64]});
    @(posedge clk); #1;
    d_addr  = a;
    d_wdata = wd;
    d_read  = !wr;
    d_write = wr;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      if (d_resp) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      fail_msg("d_resp_wait", "timeout", "d_resp");
      exp_d.delete();
      exp_w.delete();
    end
    @(posedge clk); #1;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic drive_idle();
    i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    bmem_rdy = 1; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cmd_q.delete(); exp_i.delete(); exp_d.delete(); exp_w.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bmem_read"},  256'(bmem_read),  256'(0));
    check({tag, "_bmem_write"}, 256'(bmem_write), 256'(0));
    check({tag, "_bmem_addr"},  256'(bmem_addr),  256'(0));
    check({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'(0));
    check({tag, "_i_resp"},     256'(i_resp),     256'(0));
    check({tag, "_d_resp"},     256'(d_resp),     256'(0));
    check({tag, "_i_rdata"},    i_rdata,          256'(0));
    check({tag, "_d_rdata"},    d_rdata,          256'(0));
  endtask

  task automatic wait_wbeats(input int target);
    bit ok = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk); #1;
      if (n_wbeats >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_msg("wbeat_wait", "timeout", "write beats");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc_i, rc_d, lc, base, base_w, exp_reads;
    bit ok, use_i, use_d, d_wr, rev, done;
    cmd_t c;
    logic [255:0] wd;
    logic [31:0] ai, ad;

    // reset state
    rst = 1'b0;
    drive_idle();
    #2;
    check_outputs_zero("reset");
    do_reset();

    // single icache read, request held across a long memory latency
    base = n_reads;
    fork
      i_req(32'h0000_1000, rc_i);
      begin
        wait_cmds(1, ok);
        if (ok) begin
          repeat (6) @(posedge clk);
          c = cmd_q.pop_front();
          check("t2_cmd_addr", 256'(c.addr), 256'(32'h0000_1000));
          mem_return(c.addr, lc);
        end
      end
    join
    check("t2_resp_latency", 256'(rc_i), 256'(lc + 1));
    repeat (5) @(posedge clk);
    check("t2_read_count", 256'(n_reads - base), 256'(1));

    // simultaneous i/d reads, round-robin order, reversed returns
    do_reset();
    fork
      i_req(32'h0000_1000, rc_i);
      d_req(1'b0, 32'h0000_2000, '0, rc_d);
      begin
        wait_cmds(2, ok);
        if (ok) begin
          check("t3_first_addr",  256'(cmd_q[0].addr), 256'(32'h0000_1000));
          check("t3_second_addr", 256'(cmd_q[1].addr), 256'(32'h0000_2000));
          check("t3_consecutive", 256'(cmd_q[1].cyc - cmd_q[0].cyc), 256'(1));
          serve_reads(2, 1'b1, 2);
        end
      end
    join

    // writeback with a 2-cycle stall after beat 1
    do_reset();
    wd = rand_line();
    base_w = n_wbeats;
    fork
      d_req(1'b1, 32'h0000_3000, wd, rc_d);
      begin
        wait_wbeats(base_w + 2);
        @(posedge clk); #1 bmem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 bmem_rdy = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    check("t4_beat_count", 256'(n_wbeats - base_w), 256'(4));
    check("t4_beats_left", 256'(exp_w.size()), 256'(0));
    check("t4_resp_left",  256'(exp_d.size()), 256'(0));

    // same-address reads, one return satisfies both
    do_reset();
    base = n_reads;
    fork
      i_req(32'h0000_4000, rc_i);
      d_req(1'b0, 32'h0000_4000, '0, rc_d);
      begin
        wait_cmds(2, ok);
        if (ok) begin
          c = cmd_q.pop_front();
          mem_return(c.addr, lc);
        end
      end
    join
    check("t5_same_cycle", 256'(rc_i), 256'(rc_d));
    check("t5_read_count", 256'(n_reads - base), 256'(2));
    cmd_q.delete();

    // reset during write beat 2, then a normal read
    do_reset();
    wd = rand_line();
    base_w = n_wbeats;
    d_addr = 32'h0000_5000;
    d_wdata = wd;
    for (int k = 0; k < 4; k++) exp_w.push_back('{32'h0000_5000, wd[64*k +: 64]});
    @(posedge clk); #1 d_write = 1'b1;
    wait_wbeats(base_w + 2);
    @(posedge clk); #1;
    check("t6_in_beat2", 256'(bmem_write), 256'(1));
    rst = 1'b0;
    #1;
    check_outputs_zero("t6_midburst");
    exp_w.delete();
    d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    base = n_reads;
    fork
      i_req(32'h0000_6000, rc_i);
      serve_reads(1, 1'b0, 1);
    join
    check("t6_read_count", 256'(n_reads - base), 256'(1));

    // randomized traffic with random bmem_rdy
    base = n_reads;
    exp_reads = 0;
    for (int it = 0; it < 60; it++) begin
      use_i = 1'($urandom_range(0, 1));
      use_d = 1'($urandom_range(0, 1));
      if (!use_i && !use_d) use_i = 1'b1;
      d_wr = 1'($urandom_range(0, 1));
      rev  = 1'($urandom_range(0, 1));
      ai = 32'h0001_0000 + 32'($urandom_range(0, 7)) * 32'd32;
      ad = 32'h0002_0000 + 32'($urandom_range(0, 7)) * 32'd32;
      wd = rand_line();
      exp_reads += int'(use_i) + int'(use_d && !d_wr);
      done = 1'b0;
      fork
        begin
          fork
            if (use_i) i_req(ai, rc_i);
            if (use_d) d_req(d_wr, ad, wd, rc_d);
            serve_reads(int'(use_i) + int'(use_d && !d_wr), rev, int'($urandom_range(0, 3)));
          join
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1 bmem_rdy = ($urandom_range(0, 3) != 0);
          end
        end
      join
      bmem_rdy = 1'b1;
    end
    repeat (10) @(posedge clk);
    check("rand_read_count", 256'(n_reads - base), 256'(exp_reads));
    check("rand_cmds_left",  256'(cmd_q.size()), 256'(0));
    check("rand_i_left",     256'(exp_i.size()), 256'(0));
    check("rand_d_left",     256'(exp_d.size()), 256'(0));
    check("rand_w_left",     256'(exp_w.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single burst-memory (bmem) port of `cpu` between the instruction cache (read-only) and the data cache (read and writeback).
- Serialises request issue and drives 4-beat write bursts.
- Reassembles 4-beat read returns into 256-bit lines and routes each line to its owner by matching `bmem_raddr`.
- Sits between the cache pair and the top-level `bmem_*` ports.

Parameters:
- BEATS, 4, 64-bit beats per cache line.
- ADDR_W, 32, address width; line-aligned addresses (low 5 bits zero).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_addr  in  32  icache line address
- i_read  in  1  icache read request; held until i_resp
- i_rdata  out  256  icache line data
- i_resp  out  1  one-cycle pulse: i_rdata valid
- d_addr  in  32  dcache line address
- d_read  in  1  dcache read request; held until d_resp
- d_write  in  1  dcache writeback request; held until d_resp; never together with d_read
- d_wdata  in  256  dcache writeback line
- d_rdata  out  256  dcache line data
- d_resp  out  1  one-cycle pulse: read data valid or write done
- bmem_addr  out  32  memory address
- bmem_read  out  1  read command
- bmem_write  out  1  write command/beat
- bmem_wdata  out  64  write beat
- bmem_rdy  in  1  memory accepts commands
- bmem_rvalid  in  1  read beat valid
- bmem_raddr  in  32  address of returning read
- bmem_rdata  in  64  read beat

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all pending/issued flags clear, beat counters 0, rr pointer=icache. Outputs: bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, i_resp=0, d_resp=0, i_rdata/d_rdata=0.
- Pending flag per requester: set when its command is issued, cleared on its resp. A requester with pending=1 is not eligible for issue; this prevents reissue while its request is held.
- Issue FSM:
  - IDLE: needs bmem_rdy=1. Eligible requests are i_read (!i_pend) and d_read/d_write (!d_pend). With two eligible, round-robin; rr flips to the other requester after each grant.
    - Read grant: bmem_read=1 and bmem_addr=addr for exactly 1 cycle; stay IDLE.
    - Write grant: go to WRITE with beat=0.
  - WRITE: bmem_write=1, bmem_addr=d_addr, bmem_wdata=d_wdata[64*beat +: 64] on every cycle with bmem_rdy=1; beat increments per accepted beat.
    - If bmem_rdy=0 mid-burst: deassert bmem_write and hold beat.
    - After beat BEATS-1 is accepted: d_resp=1 next cycle; return to IDLE.
  - bmem_read and bmem_write are never both 1.
- Return path (independent of FSM; a read may return during WRITE):
  - On bmem_rvalid, compare bmem_raddr with the latched addresses of pending reads.
  - Matching beat k is written to line[64*k +: 64]; the per-owner beat counter increments.
  - The cycle after the 4th beat: resp=1 for 1 cycle, line presented on rdata, pending cleared.
  - Both reads pending with equal addresses: one return satisfies both; i_resp and d_resp fire in the same cycle.
  - Return matching no pending read: ignored; SVA-flagged in simulation.
  - Beats of one return are consecutive on rvalid. Returns from different addresses do not interleave.
- rdata holds its value until the next resp for that requester.
- Reset mid-burst abandons the burst; cache state is not recovered.

Optional Feature:
- BMEM_ARB_PERF_EN defined:
  - Adds 32-bit saturating counters `perf_i_reqs`, `perf_d_reqs`, `perf_wr_bursts`, `perf_conflict_cycles`. A conflict cycle is a cycle with both requesters eligible.
  - Counters are readable through hierarchy only and cleared on reset.
- BMEM_ARB_PERF_EN undefined: no counters, no extra logic.

Decomposition:
- Shared package `bmem_pkg`:
  - BEATS, LINE_W=256, BEAT_W=64
  - typedef `arb_state_t` {IDLE, WRITE}
  - typedef `owner_t` {OWN_I, OWN_D}
- Sub-module `bmem_line_assembler`: one instance per requester. Holds the latched address, beat counter, line register and resp generation. Arbiter top holds the FSM and round-robin logic.

Test Plan:
- Icache read 0x00001000, memory returns 4 beats A,B,C,D → i_rdata={D,C,B,A}, i_resp 1 cycle after beat 3; no d_resp.
- i_read 0x1000 and d_read 0x2000 in the same cycle, rr=icache → bmem_read issued for 0x1000 then 0x2000 on consecutive rdy cycles. Returns in reverse order → each line routed to the correct owner.
- d_write 0x3000 with bmem_rdy dropped after beat 1 for 2 cycles → exactly 4 bmem_write beats, order 0..3, address held; d_resp once.
- i_read and d_read both to 0x4000 → two issues, first return delivers to both, i_resp=d_resp same cycle.
- rst asserted during WRITE beat 2 → all outputs 0 immediately; after release, a new i_read issues normally.
- Held i_read with i_pend=1 → no second bmem_read issued before i_resp.
